// File: rtl/vc_read_scheduler_if.sv
// Signal bundle between a port's multi-VC FIFO buffer / downstream credit path
// and its read scheduler. The scheduler uses the master modport.
interface vc_read_scheduler_if #(
    parameter int VC_NUM_PER_PORT = 4,
    parameter int FLIT_TYPE_WIDTH = 2
);
    logic [VC_NUM_PER_PORT-1:0] vc_not_empty;
    logic [VC_NUM_PER_PORT-1:0] credit_in;
    logic [FLIT_TYPE_WIDTH-1:0] flit_type_in;
    logic                       rd_en;
    logic [VC_NUM_PER_PORT-1:0] vc_num_rd;
    logic                       out_valid;
    logic [VC_NUM_PER_PORT-1:0] out_vc;

    modport master (
        input  vc_not_empty,
        input  credit_in,
        input  flit_type_in,
        output rd_en,
        output vc_num_rd,
        output out_valid,
        output out_vc
    );

    modport slave (
        output vc_not_empty,
        output credit_in,
        output flit_type_in,
        input  rd_en,
        input  vc_num_rd,
        input  out_valid,
        input  out_vc
    );
endinterface

// File: rtl/vc_read_scheduler.sv
// Round-robin read scheduler for a per-port multi-VC FIFO with per-VC downstream credits.
// Define VC_SCHED_PKT_LOCK_EN for packet-level (non-interleaved) scheduling.
module vc_read_scheduler #(
    parameter int VC_NUM_PER_PORT   = 4,
    parameter int BUFFER_NUM_PER_VC = 4,
    parameter int FLIT_TYPE_WIDTH   = 2
) (
    input logic                 clk,
    input logic                 reset,
    vc_read_scheduler_if.master bus
);
    localparam int unsigned V  = VC_NUM_PER_PORT;
    localparam int unsigned CW = $clog2(BUFFER_NUM_PER_VC + 1);
    localparam int unsigned PW = (V > 1) ? $clog2(V) : 1;
    localparam logic [CW-1:0] CREDIT_FULL = CW'(BUFFER_NUM_PER_VC);

    logic [CW-1:0] credit_q [V];
    logic [CW-1:0] credit_d [V];
    logic [V-1:0]  credit_ok;
    logic [V-1:0]  overflow;
    logic [V-1:0]  allowed;
    logic [V-1:0]  elig;
    logic [V-1:0]  gnt;
    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] rr_ptr_d;
    logic [PW-1:0] idx;
    logic          found;
    logic          out_valid_q;
    logic [V-1:0]  out_vc_q;
    logic [FLIT_TYPE_WIDTH-1:0] unused_flit_type;

    assign unused_flit_type = bus.flit_type_in;

    always_comb begin
        credit_ok = '0;
        for (int unsigned i = 0; i < V; i++) begin
            credit_ok[i] = (credit_q[i] != '0);
        end
    end

`ifdef VC_SCHED_PKT_LOCK_EN
    logic [V-1:0] lock_vc_q;
    logic [V-1:0] lock_vc_d;
    logic         tail_seen;

    assign allowed   = (lock_vc_q == '0) ? '1 : lock_vc_q;
    assign tail_seen = out_valid_q & (out_vc_q == lock_vc_q) & bus.flit_type_in[0];

    // A grant in the tail cycle can only be the locked VC, so it starts its next packet.
    always_comb begin
        lock_vc_d = lock_vc_q;
        if (lock_vc_q == '0) begin
            lock_vc_d = gnt;
        end else if (tail_seen) begin
            lock_vc_d = gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_vc_q <= '0;
        end else begin
            lock_vc_q <= lock_vc_d;
        end
    end
`else
    assign allowed = '1;
`endif

    assign elig = bus.vc_not_empty & credit_ok & allowed;

    // Grant stays combinational: vc_not_empty already reflects last edge's read.
    always_comb begin
        gnt      = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned j = 0; j < V; j++) begin
            idx = PW'((32'(rr_ptr_q) + j) % V);
            if (!found && elig[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                rr_ptr_d = PW'((32'(idx) + 1) % V);
            end
        end
        if (reset) begin
            gnt      = '0;
            rr_ptr_d = rr_ptr_q;
        end
    end

    always_comb begin
        overflow = '0;
        for (int unsigned i = 0; i < V; i++) begin
            credit_d[i] = credit_q[i];
            case ({gnt[i], bus.credit_in[i]})
                2'b10: credit_d[i] = credit_q[i] - CW'(1);
                2'b01: begin
                    if (credit_q[i] == CREDIT_FULL) begin
                        overflow[i] = 1'b1;
                    end else begin
                        credit_d[i] = credit_q[i] + CW'(1);
                    end
                end
                default: credit_d[i] = credit_q[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_vc_q    <= '0;
            for (int unsigned i = 0; i < V; i++) begin
                credit_q[i] <= CREDIT_FULL;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= |gnt;
            out_vc_q    <= gnt;
            credit_q    <= credit_d;
        end
    end

    assign bus.rd_en     = |gnt;
    assign bus.vc_num_rd = gnt;
    assign bus.out_valid = out_valid_q & ~reset;
    assign bus.out_vc    = reset ? '0 : out_vc_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < V; i++) begin
            if (!reset && overflow[i]) begin
                $warning(" ERROR: credit overflow: %m");
            end
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));
    a_gnt_credit: assert property (@(posedge clk) disable iff (reset) (gnt & ~credit_ok) == '0);
    a_gnt_ready:  assert property (@(posedge clk) disable iff (reset) (gnt & ~bus.vc_not_empty) == '0);
`endif
endmodule
